ram_responder: RTL and testbench

Memory-side responder for the single-cycle core's memory request interface. Accepts one read or write per transaction from the request unit (`Ren`/`Wen`/`ramaddr`/`ramstore`), models a word-organised RAM with a programmable wait-state count, and completes each transaction with a one-cycle `ram_ready` pulse that carries `ramload`. The core stalls on instruction and data access until this pulse, since the request unit derives `i_ready`/`d_ready` from it.

---
 rtl/ram_responder_if.sv | 30 +++
 rtl/ram_responder.sv | 142 ++++++++++++++
 tb/tb_ram_responder.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/ram_responder_if.sv
// ram_responder_if: request/response bundle between the core's memory request
// unit and the RAM responder.
//   Ren, Wen        - read / write request (Wen wins if both high)
//   ramaddr         - byte address, word index is ramaddr[31:2]
//   ramstore        - write data
//   ramload         - registered read data, valid with ram_ready on a read
//   ram_ready       - one-cycle completion pulse
//   ram_busy        - responder is mid-transaction
//   ram_err         - out-of-range flag, pulses with ram_ready
// Modports: master (request unit side), slave (responder side).
interface ram_responder_if;
  logic        Ren;
  logic        Wen;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic        ram_ready;
  logic        ram_busy;
  logic        ram_err;

  modport master (
    output Ren, Wen, ramaddr, ramstore,
    input  ramload, ram_ready, ram_busy, ram_err
  );

  modport slave (
    input  Ren, Wen, ramaddr, ramstore,
    output ramload, ram_ready, ram_busy, ram_err
  );
endinterface

// File: rtl/ram_responder.sv
// ram_responder: word-organised RAM model behind the core's memory request
// interface. Each accepted read/write waits LATENCY cycles, then completes with
// a one-cycle ram_ready pulse. An IDLE cycle always separates transactions.
//
// Parameters:
//   DEPTH   - number of 32-bit words (power of two, 4..1024)
//   LATENCY - wait cycles between accept and response (0..15)
// Ports:
//   clk  - clock, rising edge
//   nRST - asynchronous active-low reset (memory contents are not reset)
//   bus  - ram_responder_if.slave request/response bundle
// Build option:
//   RAM_RANGE_CHECK_EN - when defined, word indices >= DEPTH raise ram_err,
//   reads return 32'hBAD1_BAD1 and writes are dropped. When undefined the
//   index wraps modulo DEPTH and ram_err stays 0.
module ram_responder #(
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned LATENCY = 2
) (
  input logic             clk,
  input logic             nRST,
  ram_responder_if.slave  bus
);

  localparam int unsigned AW      = $clog2(DEPTH);
  localparam logic [31:0] BadData = 32'hBAD1_BAD1;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            we_q, we_d;
  logic            oor_q, oor_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [31:0]     ramload_q, ramload_d;
  logic            ready_q, ready_d;
  logic            busy_q, busy_d;
  logic            err_q, err_d;

  logic [31:0]     mem_q [DEPTH];

  logic [AW-1:0]   req_idx;
  logic            req_oor;

  assign req_idx = bus.ramaddr[AW+1:2];

`ifdef RAM_RANGE_CHECK_EN
  assign req_oor = |bus.ramaddr[31:AW+2];
`else
  assign req_oor = 1'b0;
`endif

  // Byte-offset bits never matter; upper bits only matter with the range check.
  logic unused_addr;
  assign unused_addr = ^{bus.ramaddr[1:0], bus.ramaddr[31:AW+2]};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    we_d      = we_q;
    oor_d     = oor_q;
    idx_d     = idx_q;
    wdata_d   = wdata_q;
    ramload_d = ramload_q;

    unique case (state_q)
      StIdle: begin
        if (bus.Wen || bus.Ren) begin
          we_d    = bus.Wen;
          idx_d   = req_idx;
          oor_d   = req_oor;
          wdata_d = bus.ramstore;
          cnt_d   = 4'(LATENCY);
          state_d = (LATENCY > 0) ? StWait : StResp;
        end
      end
      StWait: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = StResp;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Outputs are registered, so they are loaded on the edge entering RESP.
    // For LATENCY=0 that edge is the accept edge, hence the use of *_d here.
    if (state_d == StResp && state_q != StResp && !we_d) begin
      ramload_d = oor_d ? BadData : mem_q[idx_d];
    end

    ready_d = (state_d == StResp);
    busy_d  = (state_d != StIdle);
    err_d   = (state_d == StResp) && oor_d;
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state_q   <= StIdle;
      cnt_q     <= 4'd0;
      we_q      <= 1'b0;
      oor_q     <= 1'b0;
      idx_q     <= '0;
      wdata_q   <= 32'd0;
      ramload_q <= 32'd0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      we_q      <= we_d;
      oor_q     <= oor_d;
      idx_q     <= idx_d;
      wdata_q   <= wdata_d;
      ramload_q <= ramload_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
    end
  end

  // Commit at the end of RESP. state_q is cleared asynchronously, so a reset
  // that lands mid-transaction leaves memory untouched.
  always_ff @(posedge clk) begin
    if (state_q == StResp && we_q && !oor_q) begin
      mem_q[idx_q] <= wdata_q;
    end
  end

  assign bus.ramload   = ramload_q;
  assign bus.ram_ready = ready_q;
  assign bus.ram_busy  = busy_q;
  assign bus.ram_err   = err_q;

endmodule

// File: tb/tb_ram_responder.sv
// Directed bench for ram_responder: one instance with LATENCY=2 and one with
// LATENCY=0, sharing clock and reset.
module tb_ram_responder;

  logic clk;
  logic nRST;

  ram_responder_if bus2 ();
  ram_responder_if bus0 ();

  ram_responder #(.DEPTH(256), .LATENCY(2)) dut2 (
    .clk  (clk),
    .nRST (nRST),
    .bus  (bus2)
  );

  ram_responder #(.DEPTH(256), .LATENCY(0)) dut0 (
    .clk  (clk),
    .nRST (nRST),
    .bus  (bus0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set_req(input bit sel, input logic ren, input logic wen,
                         input logic [31:0] addr, input logic [31:0] data);
    if (sel) begin
      bus2.Ren = ren; bus2.Wen = wen; bus2.ramaddr = addr; bus2.ramstore = data;
    end else begin
      bus0.Ren = ren; bus0.Wen = wen; bus0.ramaddr = addr; bus0.ramstore = data;
    end
  endtask

  task automatic sample(input bit sel, output logic busy, output logic ready,
                        output logic err, output logic [31:0] load);
    if (sel) begin
      busy = bus2.ram_busy; ready = bus2.ram_ready; err = bus2.ram_err; load = bus2.ramload;
    end else begin
      busy = bus0.ram_busy; ready = bus0.ram_ready; err = bus0.ram_err; load = bus0.ramload;
    end
  endtask

  // Request seen in cycle 0, held until ram_ready, then one extra IDLE cycle
  // is sampled. Returns the ready cycle (-1 on timeout) and pulse/busy counts.
  task automatic txn(input bit sel, input logic ren, input logic wen,
                     input logic [31:0] addr, input logic [31:0] data,
                     output int rdy_cyc, output int rdy_cnt, output int busy_cnt,
                     output logic [31:0] load, output logic err);
    logic b, r, e;
    logic [31:0] l;
    bit done;
    @(negedge clk);
    set_req(sel, ren, wen, addr, data);
    rdy_cyc  = -1;
    rdy_cnt  = 0;
    busy_cnt = 0;
    load     = 32'd0;
    err      = 1'b0;
    done     = 1'b0;
    for (int c = 1; c <= 40 && !done; c++) begin
      @(posedge clk);
      #1;
      sample(sel, b, r, e, l);
      if (b) busy_cnt++;
      if (r) rdy_cnt++;
      if (rdy_cyc >= 0) begin
        done = 1'b1;
      end else if (r) begin
        rdy_cyc = c;
        load    = l;
        err     = e;
        set_req(sel, 1'b0, 1'b0, addr, data);
      end
    end
    set_req(sel, 1'b0, 1'b0, addr, data);
  endtask

  int          rc, rn, bn;
  logic [31:0] ld;
  logic        er;
  logic        b, r, e;
  logic [31:0] l;
  logic [31:0] rdy_mask, busy_mask;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    nRST = 1'b0;
    set_req(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    set_req(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    sample(1'b1, b, r, e, l);
    check_eq("reset_busy", 32'(b), 32'd0);
    check_eq("reset_ready", 32'(r), 32'd0);
    check_eq("reset_err", 32'(e), 32'd0);
    check_eq("reset_ramload", l, 32'd0);
    @(negedge clk);
    nRST = 1'b1;

    // LATENCY=2 write then read back.
    txn(1'b1, 1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, rc, rn, bn, ld, er);
    check_eq("wr10_ready_cycle", 32'(rc), 32'd3);
    check_eq("wr10_ready_pulses", 32'(rn), 32'd1);
    check_eq("wr10_busy_cycles", 32'(bn), 32'd3);
    check_eq("wr10_err", 32'(er), 32'd0);
    txn(1'b1, 1'b1, 1'b0, 32'h10, 32'd0, rc, rn, bn, ld, er);
    check_eq("rd10_ready_cycle", 32'(rc), 32'd3);
    check_eq("rd10_data", ld, 32'hDEAD_BEEF);

    // A write leaves ramload alone; byte offset bits are ignored.
    txn(1'b1, 1'b0, 1'b1, 32'h04, 32'hCAFE_F00D, rc, rn, bn, ld, er);
    check_eq("wr04_ramload_held", ld, 32'hDEAD_BEEF);
    txn(1'b1, 1'b1, 1'b0, 32'h07, 32'd0, rc, rn, bn, ld, er);
    check_eq("rd07_alias_word1", ld, 32'hCAFE_F00D);

    // Top word of the array.
    txn(1'b1, 1'b0, 1'b1, 32'h3FC, 32'h7E57_00FF, rc, rn, bn, ld, er);
    txn(1'b1, 1'b1, 1'b0, 32'h3FC, 32'd0, rc, rn, bn, ld, er);
    check_eq("rd3fc_data", ld, 32'h7E57_00FF);

    // LATENCY=0, Ren and Wen together behave as a write.
    txn(1'b0, 1'b1, 1'b1, 32'h20, 32'h1234_5678, rc, rn, bn, ld, er);
    check_eq("l0_wr_ready_cycle", 32'(rc), 32'd1);
    check_eq("l0_wr_busy_cycles", 32'(bn), 32'd1);
    check_eq("l0_wr_ramload_held", ld, 32'd0);
    txn(1'b0, 1'b1, 1'b0, 32'h20, 32'd0, rc, rn, bn, ld, er);
    check_eq("l0_rd_ready_cycle", 32'(rc), 32'd1);
    check_eq("l0_rd_data", ld, 32'h1234_5678);

    // Reset during WAIT of a write discards it.
    txn(1'b1, 1'b0, 1'b1, 32'h40, 32'h0000_0001, rc, rn, bn, ld, er);
    txn(1'b1, 1'b1, 1'b0, 32'h40, 32'd0, rc, rn, bn, ld, er);
    check_eq("rd40_before", ld, 32'h0000_0001);
    @(negedge clk);
    set_req(1'b1, 1'b0, 1'b1, 32'h40, 32'hFFFF_FFFF);
    @(posedge clk);
    #1;
    sample(1'b1, b, r, e, l);
    check_eq("mid_busy_before_reset", 32'(b), 32'd1);
    #2;
    nRST = 1'b0;
    #1;
    sample(1'b1, b, r, e, l);
    check_eq("mid_reset_busy", 32'(b), 32'd0);
    check_eq("mid_reset_ready", 32'(r), 32'd0);
    check_eq("mid_reset_ramload", l, 32'd0);
    set_req(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    @(posedge clk);
    @(negedge clk);
    nRST = 1'b1;
    txn(1'b1, 1'b1, 1'b0, 32'h40, 32'd0, rc, rn, bn, ld, er);
    check_eq("rd40_after_reset", ld, 32'h0000_0001);

    // Index 256 on DEPTH=256.
    txn(1'b1, 1'b0, 1'b1, 32'h00, 32'h5555_AAAA, rc, rn, bn, ld, er);
    txn(1'b1, 1'b1, 1'b0, 32'h400, 32'd0, rc, rn, bn, ld, er);
`ifdef RAM_RANGE_CHECK_EN
    check_eq("rd400_err", 32'(er), 32'd1);
    check_eq("rd400_data", ld, 32'hBAD1_BAD1);
`else
    check_eq("rd400_err", 32'(er), 32'd0);
    check_eq("rd400_data", ld, 32'h5555_AAAA);
`endif
    txn(1'b1, 1'b0, 1'b1, 32'h400, 32'h0BAD_F00D, rc, rn, bn, ld, er);
    txn(1'b1, 1'b1, 1'b0, 32'h00, 32'd0, rc, rn, bn, ld, er);
`ifdef RAM_RANGE_CHECK_EN
    check_eq("rd00_after_oor_wr", ld, 32'h5555_AAAA);
`else
    check_eq("rd00_after_oor_wr", ld, 32'h0BAD_F00D);
`endif
    check_eq("rd00_err", 32'(er), 32'd0);

    // Ren held continuously: ready in cycles 3,7,11,15; IDLE in 4,8,12,16.
    rdy_mask  = 32'd0;
    busy_mask = 32'd0;
    @(negedge clk);
    set_req(1'b1, 1'b1, 1'b0, 32'h10, 32'd0);
    for (int c = 1; c <= 16; c++) begin
      @(posedge clk);
      #1;
      sample(1'b1, b, r, e, l);
      if (r) rdy_mask[c] = 1'b1;
      if (b) busy_mask[c] = 1'b1;
    end
    set_req(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    check_eq("held_ren_ready_mask", rdy_mask, 32'h0000_8888);
    check_eq("held_ren_busy_mask", busy_mask, 32'h0000_EEEE);
    check_eq("held_ren_data", l, 32'hDEAD_BEEF);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
